// File: rtl/ascii_bus_decoder.sv
// ascii_bus_decoder
//   Receive-side bridge from the UART receiver to the daisy-chained bus cores.
//   Parses ASCII request messages and emits one single-cycle bus transaction
//   for each well-formed message. Malformed messages are dropped silently.
//
//   Message formats (hex digits are MSB first, 0-9 / A-F / a-f):
//     'R' <ADDR_DIGITS hex> <CR|LF>                  -> read
//     'W' <ADDR_DIGITS hex> <DATA_DIGITS hex> <CR|LF>  -> write
//   An 'R' or 'W' in the middle of a message abandons it and starts a new one.
//
//   Ports:
//     clk          system clock, rising edge
//     rst          asynchronous active-high reset
//     data_i[7:0]  received ASCII byte
//     valid_i      data_i qualifier, one byte consumed per cycle when high
//     addr_o       bus address (4*ADDR_DIGITS bits)
//     wdata_o      bus write data (4*DATA_DIGITS bits), held across reads
//     rw_o         1 = write, 0 = read
//     valid_o      single-cycle transaction strobe
//     err_count_o  [15:0] saturating discard counter, only present when
//                  ASCII_BUS_DECODER_ERR_COUNT_EN is defined
module ascii_bus_decoder #(
    parameter int unsigned ADDR_DIGITS = 4,
    parameter int unsigned DATA_DIGITS = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [7:0]                 data_i,
    input  logic                       valid_i,
    output logic [4*ADDR_DIGITS-1:0]   addr_o,
    output logic [4*DATA_DIGITS-1:0]   wdata_o,
    output logic                       rw_o,
    output logic                       valid_o
`ifdef ASCII_BUS_DECODER_ERR_COUNT_EN
    ,
    output logic [15:0]                err_count_o
`endif
);

    localparam int unsigned AW  = 4 * ADDR_DIGITS;
    localparam int unsigned DW  = 4 * DATA_DIGITS;
    localparam int unsigned TOT = ADDR_DIGITS + DATA_DIGITS;
    localparam int unsigned CW  = $clog2(TOT + 1);

    localparam logic [CW-1:0] CNT_ADDR = CW'(ADDR_DIGITS);
    localparam logic [CW-1:0] CNT_FULL = CW'(TOT);

    localparam logic [7:0] CH_R  = 8'h52;
    localparam logic [7:0] CH_W  = 8'h57;
    localparam logic [7:0] CH_CR = 8'h0D;
    localparam logic [7:0] CH_LF = 8'h0A;

    typedef enum logic [1:0] {
        IDLE,
        READ,
        WRITE
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [AW-1:0]   addr_sh_q, addr_sh_d;
    logic [DW-1:0]   data_sh_q, data_sh_d;

    logic [AW-1:0]   addr_q;
    logic [DW-1:0]   wdata_q;
    logic            rw_q;
    logic            valid_q;

    logic            commit;
    logic            discard;

    // Byte classification
    logic            is_hex;
    logic [3:0]      nib;
    logic [7:0]      hex_tmp;
    logic            is_term;
    logic            is_r;
    logic            is_w;
    logic            full;

    always_comb begin
        is_hex  = 1'b0;
        hex_tmp = '0;
        if (data_i >= 8'h30 && data_i <= 8'h39) begin
            is_hex  = 1'b1;
            hex_tmp = data_i - 8'h30;
        end else if (data_i >= 8'h41 && data_i <= 8'h46) begin
            is_hex  = 1'b1;
            hex_tmp = data_i - 8'h37;
        end else if (data_i >= 8'h61 && data_i <= 8'h66) begin
            is_hex  = 1'b1;
            hex_tmp = data_i - 8'h57;
        end
        nib     = hex_tmp[3:0];
        is_term = (data_i == CH_CR) || (data_i == CH_LF);
        is_r    = (data_i == CH_R);
        is_w    = (data_i == CH_W);
        full    = (state_q == WRITE) ? (cnt_q == CNT_FULL) : (cnt_q == CNT_ADDR);
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        addr_sh_d = addr_sh_q;
        data_sh_d = data_sh_q;
        commit    = 1'b0;
        discard   = 1'b0;

        if (valid_i) begin
            if (state_q == IDLE) begin
                // Anything other than a start character is ignored here,
                // which is what makes the LF of a CRLF pair harmless.
                if (is_r) begin
                    state_d = READ;
                    cnt_d   = '0;
                end else if (is_w) begin
                    state_d = WRITE;
                    cnt_d   = '0;
                end
            end else begin
                if (is_r || is_w) begin
                    // Resync: restart on the new start character.
                    discard = 1'b1;
                    state_d = is_r ? READ : WRITE;
                    cnt_d   = '0;
                end else if (is_term) begin
                    state_d = IDLE;
                    if (full) begin
                        commit = 1'b1;
                    end else begin
                        discard = 1'b1;
                    end
                end else if (is_hex && !full) begin
                    cnt_d = cnt_q + CW'(1);
                    // A full read/write always shifts in every digit, so
                    // stale contents from older messages are pushed out.
                    if (cnt_q < CNT_ADDR) begin
                        addr_sh_d = (addr_sh_q << 4) | AW'(nib);
                    end else begin
                        data_sh_d = (data_sh_q << 4) | DW'(nib);
                    end
                end else begin
                    discard = 1'b1;
                    state_d = IDLE;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            addr_sh_q <= '0;
            data_sh_q <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
            rw_q      <= 1'b0;
            valid_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            addr_sh_q <= addr_sh_d;
            data_sh_q <= data_sh_d;
            valid_q   <= commit;
            if (commit) begin
                addr_q <= addr_sh_q;
                rw_q   <= (state_q == WRITE);
                if (state_q == WRITE) begin
                    wdata_q <= data_sh_q;
                end
            end
        end
    end

    assign addr_o  = addr_q;
    assign wdata_o = wdata_q;
    assign rw_o    = rw_q;
    assign valid_o = valid_q;

`ifdef ASCII_BUS_DECODER_ERR_COUNT_EN
    logic [15:0] err_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_q <= '0;
        end else if (discard && (err_q != '1)) begin
            err_q <= err_q + 16'd1;
        end
    end

    assign err_count_o = err_q;
`endif

endmodule

// File: tb/tb_ascii_bus_decoder.sv
module tb_ascii_bus_decoder;

    localparam int unsigned AD = 4;
    localparam int unsigned DD = 4;

    logic              clk;
    logic              rst;
    logic [7:0]        data_i;
    logic              valid_i;
    logic [4*AD-1:0]   addr_o;
    logic [4*DD-1:0]   wdata_o;
    logic              rw_o;
    logic              valid_o;
`ifdef ASCII_BUS_DECODER_ERR_COUNT_EN
    logic [15:0]       err_count_o;
`endif

    ascii_bus_decoder #(
        .ADDR_DIGITS (AD),
        .DATA_DIGITS (DD)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .data_i      (data_i),
        .valid_i     (valid_i),
        .addr_o      (addr_o),
        .wdata_o     (wdata_o),
        .rw_o        (rw_o),
        .valid_o     (valid_o)
`ifdef ASCII_BUS_DECODER_ERR_COUNT_EN
        ,
        .err_count_o (err_count_o)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int checks   = 0;
    int failures = 0;
    int pulses   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: tracks the text of the current message and judges it
    // when a terminator arrives.
    bit          m_active;
    bit          m_write;
    int          m_digs[$];
    logic [31:0] exp_addr, exp_wdata;
    logic        exp_rw, exp_valid;
    int          exp_err;

    function automatic int hexval(input logic [7:0] b);
        if (b >= "0" && b <= "9") return int'(b) - 48;
        if (b >= "A" && b <= "F") return int'(b) - 55;
        if (b >= "a" && b <= "f") return int'(b) - 87;
        return -1;
    endfunction

    function automatic void err_inc();
        if (exp_err < 65535) exp_err++;
    endfunction

    function automatic void model_reset();
        m_active  = 0;
        m_write   = 0;
        m_digs.delete();
        exp_addr  = 0;
        exp_wdata = 0;
        exp_rw    = 0;
        exp_valid = 0;
        exp_err   = 0;
    endfunction

    function automatic void model_byte(input logic [7:0] b);
        int need;
        int v;
        exp_valid = 0;
        if (b == "R" || b == "W") begin
            if (m_active) err_inc();
            m_active = 1;
            m_write  = (b == "W");
            m_digs.delete();
        end else if (m_active) begin
            need = m_write ? int'(AD + DD) : int'(AD);
            if (b == 8'h0D || b == 8'h0A) begin
                if (m_digs.size() == need) begin
                    v = 0;
                    for (int i = 0; i < int'(AD); i++) v = v * 16 + m_digs[i];
                    exp_addr = v;
                    exp_rw   = m_write;
                    if (m_write) begin
                        v = 0;
                        for (int i = int'(AD); i < need; i++) v = v * 16 + m_digs[i];
                        exp_wdata = v;
                    end
                    exp_valid = 1;
                end else begin
                    err_inc();
                end
                m_active = 0;
            end else if (hexval(b) >= 0 && m_digs.size() < need) begin
                m_digs.push_back(hexval(b));
            end else begin
                err_inc();
                m_active = 0;
            end
        end
    endfunction

    task automatic compare_outputs();
        check("valid", 32'(valid_o), 32'(exp_valid));
        check("addr", 32'(addr_o), exp_addr);
        check("wdata", 32'(wdata_o), exp_wdata);
        check("rw", 32'(rw_o), 32'(exp_rw));
`ifdef ASCII_BUS_DECODER_ERR_COUNT_EN
        check("err_count", 32'(err_count_o), 32'(exp_err));
`endif
    endtask

    // One clock: check what the previous byte produced, then present the next.
    task automatic step(input logic v, input logic [7:0] b);
        @(posedge clk);
        #1;
        compare_outputs();
        if (valid_o) pulses++;
        data_i  = b;
        valid_i = v;
        if (v) model_byte(b);
        else   exp_valid = 0;
    endtask

    task automatic send_str(input string s, input int gap);
        for (int i = 0; i < s.len(); i++) begin
            if (gap > 0) repeat ($urandom_range(0, gap)) step(1'b0, 8'h00);
            step(1'b1, s[i]);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, 8'h00);
    endtask

    function automatic logic [7:0] rand_hex();
        int v;
        v = $urandom_range(0, 15);
        if (v < 10) return 8'(48 + v);
        return ($urandom_range(0, 1) != 0) ? 8'(55 + v) : 8'(87 + v);
    endfunction

    initial begin
        string junk;
        int    base_err;
        logic [7:0] jb;

        junk = "RW0123456789abcdefABCDEFXzg :";
        model_reset();
        rst     = 1'b1;
        data_i  = 8'h00;
        valid_i = 1'b0;
        #12;
        compare_outputs();
        rst = 1'b0;

        // Simple read
        pulses = 0;
        send_str("R0001", 0); step(1'b1, 8'h0D);
        idle(2);
        check("read_pulses", 32'(pulses), 32'd1);
        check("read_addr", 32'(addr_o), 32'h0001);
        check("read_rw", 32'(rw_o), 32'd0);

        // Write then read with CRLF
        pulses = 0;
        send_str("W0001beef", 0); step(1'b1, 8'h0A);
        idle(2);
        check("write_pulses", 32'(pulses), 32'd1);
        check("write_wdata", 32'(wdata_o), 32'hBEEF);
        pulses = 0;
        send_str("R0001", 0); step(1'b1, 8'h0D); step(1'b1, 8'h0A);
        idle(2);
        check("crlf_pulses", 32'(pulses), 32'd1);
        check("crlf_wdata_held", 32'(wdata_o), 32'hBEEF);

        // Malformed sequences
        pulses   = 0;
        base_err = exp_err;
        send_str("R00", 0); step(1'b1, 8'h0D);
        send_str("W00010004X", 0); step(1'b1, 8'h0D);
        send_str("R00012", 0); step(1'b1, 8'h0D);
        idle(2);
        check("malformed_pulses", 32'(pulses), 32'd0);
`ifdef ASCII_BUS_DECODER_ERR_COUNT_EN
        check("malformed_errs", 32'(int'(err_count_o) - base_err), 32'd3);
`endif

        // Resync
        pulses   = 0;
        base_err = exp_err;
        send_str("W00R0002", 0); step(1'b1, 8'h0D);
        idle(2);
        check("resync_pulses", 32'(pulses), 32'd1);
        check("resync_addr", 32'(addr_o), 32'h0002);
`ifdef ASCII_BUS_DECODER_ERR_COUNT_EN
        check("resync_errs", 32'(int'(err_count_o) - base_err), 32'd1);
`endif

        // Gapped valid_i
        pulses = 0;
        send_str("W00AB1234", 3); step(1'b1, 8'h0D);
        idle(2);
        check("gap_pulses", 32'(pulses), 32'd1);
        check("gap_addr", 32'(addr_o), 32'h00AB);
        check("gap_wdata", 32'(wdata_o), 32'h1234);
        check("gap_rw", 32'(rw_o), 32'd1);

        // Back-to-back: new start byte in the same cycle as the strobe
        pulses = 0;
        send_str("R0011", 0); step(1'b1, 8'h0D);
        send_str("W00221234", 0); step(1'b1, 8'h0D);
        idle(2);
        check("b2b_pulses", 32'(pulses), 32'd2);

        // Reset mid-message
        send_str("W0001", 0);
        step(1'b0, 8'h00);
        #2;
        rst = 1'b1;
        #1;
        check("rst_valid", 32'(valid_o), 32'd0);
        check("rst_addr", 32'(addr_o), 32'd0);
        check("rst_wdata", 32'(wdata_o), 32'd0);
        check("rst_rw", 32'(rw_o), 32'd0);
        model_reset();
        #1;
        rst = 1'b0;
        pulses = 0;
        idle(2);
        send_str("R0003", 0); step(1'b1, 8'h0D);
        idle(2);
        check("post_rst_pulses", 32'(pulses), 32'd1);
        check("post_rst_addr", 32'(addr_o), 32'h0003);

        // Randomized traffic
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 9) < 6) begin
                int w;
                int nd;
                w  = $urandom_range(0, 1);
                nd = w ? int'(AD + DD) : int'(AD);
                if ($urandom_range(0, 7) == 0) nd = nd + $urandom_range(0, 2) - 1;
                if ($urandom_range(0, 2) == 0) idle($urandom_range(0, 2));
                step(1'b1, w ? "W" : "R");
                for (int k = 0; k < nd; k++) begin
                    if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
                    step(1'b1, rand_hex());
                end
                case ($urandom_range(0, 2))
                    0: step(1'b1, 8'h0D);
                    1: step(1'b1, 8'h0A);
                    default: begin step(1'b1, 8'h0D); step(1'b1, 8'h0A); end
                endcase
            end else begin
                jb = junk[$urandom_range(0, junk.len() - 1)];
                if ($urandom_range(0, 3) == 0) jb = ($urandom_range(0, 1) != 0) ? 8'h0D : 8'h0A;
                step(1'b1, jb);
            end
        end
        idle(3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
